// File: rtl/mod_down_counter_if.sv
// Load-port interface for mod_down_counter.
//   ld_valid  load request (master -> slave)
//   ld_val    start value  (master -> slave)
//   ld_ready  load accepted this cycle when high (slave -> master)
interface mod_down_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             ld_valid;
  logic             ld_ready;
  logic [WIDTH-1:0] ld_val;

  modport master (output ld_valid, output ld_val, input ld_ready);
  modport slave  (input ld_valid, input ld_val, output ld_ready);
endinterface

// File: rtl/mod_down_counter.sv
// Loadable modulo down counter (countdown timer).
// A start value is accepted on the load port while not running. The block then
// counts down on enabled cycles to zero, flags the terminal count with a single
// cycle tc pulse, and either stops (DONE) or reloads and keeps running.
// Ports:
//   clk          clock, rising edge
//   clr          synchronous active-high reset
//   en           count enable (only used while running)
//   auto_reload  1 = reload the start value at terminal count and keep running
//   ld           load port (ld_valid / ld_ready / ld_val), slave side
//   q            current count, always within 0..MAX-1
//   tc           terminal-count pulse, one cycle wide
//   busy         high while running
//   done         high while stopped at terminal count
module mod_down_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = (1 << WIDTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              auto_reload,
  mod_down_counter_if.slave ld,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              busy,
  output logic              done
);

  localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             tc_nxt;

  // Fold an arbitrary load value into the legal count range 0..MAX-1.
  function automatic logic [WIDTH-1:0] mod_reduce(input logic [WIDTH-1:0] v);
    return WIDTH'(32'(v) % 32'(MAX));
  endfunction

  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign ld.ld_ready = !busy;

  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    reload_nxt = reload;
    tc_nxt     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (ld.ld_valid) begin
          q_nxt      = mod_reduce(ld.ld_val);
          reload_nxt = mod_reduce(ld.ld_val);
          state_nxt  = RUN;
        end
      end
      RUN: begin
        if (en) begin
          if (q == '0) begin
            // Terminal edge: q stays 0 when stopping, else restart from reload.
            tc_nxt = 1'b1;
            if (auto_reload) begin
              q_nxt = reload;
            end else begin
              state_nxt = DONE;
            end
          end else begin
            q_nxt = q - WIDTH'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        q_nxt     = '0;
      end
    endcase
  end

  // clr overrides every load, count and terminal event, so tc never fires on reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      q      <= '0;
      tc     <= 1'b0;
      reload <= MAX_M1;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      tc     <= tc_nxt;
      reload <= reload_nxt;
    end
  end

endmodule
